// File: rtl/maze_pkg.sv
// Shared constants, FSM states and index helper for the maze writer.
// Coordinates are 7 bits; bitmap indices are 14 bits.
package maze_pkg;

    localparam int DEF_MAX_W    = 100;
    localparam int DEF_MAX_H    = 100;
    localparam int DEF_STACK_AW = 12;

    localparam int CW = 7;
    localparam int IW = 14;

    localparam logic [15:0]   LFSR_ZERO_SUB = 16'hACE1;
    localparam logic [CW-1:0] STEP          = 7'd2;

    typedef enum logic [2:0] {
        IDLE,
        CHECK,
        PICK,
        CARVE,
        POP,
        LOAD,
        FINISH,
        DONE
    } state_e;

    // Scan order before rotation; offsets are (0,-STEP) (+STEP,0) (0,+STEP) (-STEP,0).
    typedef enum logic [1:0] {
        DIR_N,
        DIR_E,
        DIR_S,
        DIR_W
    } dir_e;

    typedef struct packed {
        logic [CW-1:0] y;
        logic [CW-1:0] x;
    } cell_t;

    function automatic logic [IW-1:0] idx(
        input logic [CW-1:0] x,
        input logic [CW-1:0] y,
        input logic [IW-1:0] pitch
    );
        return IW'(x) + pitch * IW'(y);
    endfunction

endpackage

// File: rtl/maze_lfsr16.sv
// 16-bit Fibonacci LFSR, x^16+x^14+x^13+x^11+1, shifting right.
// A zero seed would lock up, so it is swapped for a fixed nonzero value.
module maze_lfsr16
    import maze_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        load,
    input  logic        en,
    input  logic [15:0] seed,
    output logic [15:0] state
);

    logic [15:0] state_q;
    logic [15:0] state_d;
    logic        fb;

    always_comb begin
        fb      = state_q[0] ^ state_q[2] ^ state_q[3] ^ state_q[5];
        state_d = state_q;
        if (load) begin
            state_d = (seed == 16'h0) ? LFSR_ZERO_SUB : seed;
        end else if (en) begin
            state_d = {fb, state_q[15:1]};
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= LFSR_ZERO_SUB;
        end else begin
            state_q <= state_d;
        end
    end

    assign state = state_q;

endmodule

// File: rtl/maze_path_writer.sv
// Randomized iterative DFS maze carver writing a flat wall bitmap.
// Cells sit at odd (x,y); a set bit is a wall or an unvisited cell.
module maze_path_writer
    import maze_pkg::*;
#(
    parameter int MAX_W    = DEF_MAX_W,
    parameter int MAX_H    = DEF_MAX_H,
    parameter int STACK_AW = DEF_STACK_AW
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   start,
    input  logic [6:0]             maze_width,
    input  logic [6:0]             maze_height,
    input  logic [15:0]            seed,
    output logic                   busy,
    output logic                   done,
    output logic                   err,
    output logic [MAX_W*MAX_H-1:0] path_data
);

    localparam int                  NB     = MAX_W * MAX_H;
    localparam logic [IW-1:0]       PITCH  = IW'(MAX_W);
    localparam logic [CW:0]         MAXW8  = (CW+1)'(MAX_W);
    localparam logic [CW:0]         MAXH8  = (CW+1)'(MAX_H);
    localparam logic [STACK_AW-1:0] SP_ONE = STACK_AW'(1);

    state_e              state_q, state_d;
    logic [CW-1:0]       w_q, w_d;
    logic [CW-1:0]       h_q, h_d;
    cell_t               cur_q, cur_d;
    cell_t               tgt_q, tgt_d;
    logic [STACK_AW-1:0] sp_q, sp_d;
    logic                err_q, err_d;
    logic [NB-1:0]       path_q, path_d;

    cell_t               stk_mem [2**STACK_AW];
    cell_t               stk_rd_q;

    logic [15:0]         lfsr;
    logic                lfsr_unused;
    logic                accept;
    logic                dims_bad;
    logic [3:0]          in_b;
    logic [3:0]          cand;
    logic [CW-1:0]       cand_x [4];
    logic [CW-1:0]       cand_y [4];
    logic                found;
    logic [1:0]          pick_dir;
    logic [1:0]          rot;
    logic [CW-1:0]       wall_x;
    logic [CW-1:0]       wall_y;

    maze_lfsr16 u_lfsr (
        .clk   (clk),
        .reset (reset),
        .load  (accept),
        .en    (busy),
        .seed  (seed),
        .state (lfsr)
    );

    assign lfsr_unused = ^lfsr[15:2];

    assign accept = start && (state_q == IDLE || state_q == DONE);

    assign dims_bad = !w_q[0] || !h_q[0]
                   || (w_q < 7'd3) || (h_q < 7'd3)
                   || ({1'b0, w_q} > MAXW8)
                   || ({1'b0, h_q} > MAXH8);

    // Bounds are resolved first; an out-of-range direction indexes cur instead.
    always_comb begin
        in_b = '0;
        for (int d = 0; d < 4; d++) begin
            cand_x[d] = cur_q.x;
            cand_y[d] = cur_q.y;
        end
        if (cur_q.y >= 7'd3) begin
            in_b[DIR_N]   = 1'b1;
            cand_y[DIR_N] = cur_q.y - STEP;
        end
        if ({1'b0, cur_q.x} + 8'd4 <= {1'b0, w_q}) begin
            in_b[DIR_E]   = 1'b1;
            cand_x[DIR_E] = cur_q.x + STEP;
        end
        if ({1'b0, cur_q.y} + 8'd4 <= {1'b0, h_q}) begin
            in_b[DIR_S]   = 1'b1;
            cand_y[DIR_S] = cur_q.y + STEP;
        end
        if (cur_q.x >= 7'd3) begin
            in_b[DIR_W]   = 1'b1;
            cand_x[DIR_W] = cur_q.x - STEP;
        end
        for (int d = 0; d < 4; d++) begin
            cand[d] = in_b[d] && path_q[idx(cand_x[d], cand_y[d], PITCH)];
        end
    end

    always_comb begin
        found    = 1'b0;
        pick_dir = lfsr[1:0];
        rot      = lfsr[1:0];
        for (int i = 0; i < 4; i++) begin
            rot = lfsr[1:0] + 2'(i);
            if (!found && cand[rot]) begin
                found    = 1'b1;
                pick_dir = rot;
            end
        end
    end

    assign wall_x = CW'(({1'b0, cur_q.x} + {1'b0, tgt_q.x}) >> 1);
    assign wall_y = CW'(({1'b0, cur_q.y} + {1'b0, tgt_q.y}) >> 1);

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            w_q     <= '0;
            h_q     <= '0;
            cur_q   <= '0;
            tgt_q   <= '0;
            sp_q    <= '0;
            err_q   <= 1'b0;
            path_q  <= '1;
        end else begin
            state_q <= state_d;
            w_q     <= w_d;
            h_q     <= h_d;
            cur_q   <= cur_d;
            tgt_q   <= tgt_d;
            sp_q    <= sp_d;
            err_q   <= err_d;
            path_q  <= path_d;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset && state_q == CARVE) begin
            stk_mem[sp_q] <= cur_q;
        end
        if (state_q == POP) begin
            stk_rd_q <= stk_mem[sp_q - SP_ONE];
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE, DONE: if (accept) state_d = CHECK;
            CHECK:      state_d = dims_bad ? DONE : PICK;
            PICK:       state_d = found ? CARVE : POP;
            CARVE:      state_d = PICK;
            POP:        state_d = (sp_q == '0) ? FINISH : LOAD;
            LOAD:       state_d = PICK;
            FINISH:     state_d = DONE;
            default:    state_d = IDLE;
        endcase
    end

    always_comb begin
        w_d    = w_q;
        h_d    = h_q;
        cur_d  = cur_q;
        tgt_d  = tgt_q;
        sp_d   = sp_q;
        err_d  = err_q;
        path_d = path_q;
        case (state_q)
            IDLE, DONE: begin
                if (accept) begin
                    w_d    = maze_width;
                    h_d    = maze_height;
                    sp_d   = '0;
                    err_d  = 1'b0;
                    path_d = '1;
                end
            end
            CHECK: begin
                if (dims_bad) begin
                    err_d = 1'b1;
                end else begin
                    path_d[idx(7'd1, 7'd1, PITCH)] = 1'b0;
                    cur_d = '{y: 7'd1, x: 7'd1};
                end
            end
            PICK: begin
                tgt_d = '{y: cand_y[pick_dir], x: cand_x[pick_dir]};
            end
            CARVE: begin
                path_d[idx(wall_x, wall_y, PITCH)]   = 1'b0;
                path_d[idx(tgt_q.x, tgt_q.y, PITCH)] = 1'b0;
                cur_d = tgt_q;
                sp_d  = sp_q + SP_ONE;
            end
            LOAD: begin
                cur_d = stk_rd_q;
                sp_d  = sp_q - SP_ONE;
            end
            FINISH: begin
                path_d[idx(7'd0, 7'd1, PITCH)]               = 1'b0;
                path_d[idx(w_q - 7'd1, h_q - 7'd2, PITCH)] = 1'b0;
            end
            default: begin
            end
        endcase
    end

    always_comb begin
        busy = 1'b0;
        done = 1'b0;
        case (state_q)
            IDLE:    busy = 1'b0;
            DONE:    done = 1'b1;
            default: busy = 1'b1;
        endcase
    end

    assign err       = err_q;
    assign path_data = path_q;

endmodule

// File: tb/tb_maze_path_writer.sv
// Bench for maze_path_writer: cycle-timed DFS reference model plus
// structural maze checks (tree shape, connectivity, bounds).
module tb_maze_path_writer;

    localparam int MW = 100;
    localparam int MH = 100;
    localparam int NB = MW * MH;

    logic          clk = 1'b0;
    logic          reset;
    logic          start;
    logic [6:0]    maze_width;
    logic [6:0]    maze_height;
    logic [15:0]   seed;
    logic          busy;
    logic          done;
    logic          err;
    logic [NB-1:0] path_data;

    logic [NB-1:0] m_img;
    logic [NB-1:0] img1;

    int n_vec = 0;
    int n_bad = 0;

    maze_path_writer dut (
        .clk         (clk),
        .reset       (reset),
        .start       (start),
        .maze_width  (maze_width),
        .maze_height (maze_height),
        .seed        (seed),
        .busy        (busy),
        .done        (done),
        .err         (err),
        .path_data   (path_data)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input longint obs, input longint exp);
        n_vec++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, want %0d", tag, obs, exp);
        end
    endtask

    function automatic logic [15:0] lstep(input logic [15:0] s);
        return {s[0] ^ s[2] ^ s[3] ^ s[5], s[15:1]};
    endfunction

    // Reference: DFS over cells with the generator's per-state cycle costs,
    // the LFSR stepping once per cycle from CHECK (t=0) onward.
    task automatic model_run(input int w, input int h, input logic [15:0] sd,
                             output int t_done, output bit e);
        int dx [4] = '{0, 2, 0, -2};
        int dy [4] = '{-2, 0, 2, 0};
        logic [15:0] l;
        int t, cx, cy, tx, ty, d, nx, ny;
        int sx [$];
        int sy [$];
        bit fnd;
        m_img = '1;
        e = 0;
        l = (sd == 16'h0) ? 16'hACE1 : sd;
        if (w % 2 == 0 || h % 2 == 0 || w < 3 || h < 3 || w > MW || h > MH) begin
            e = 1;
            t_done = 1;
            return;
        end
        m_img[1 + MW] = 1'b0;
        cx = 1;
        cy = 1;
        t = 1;
        l = lstep(l);
        forever begin
            fnd = 0;
            tx = cx;
            ty = cy;
            for (int i = 0; i < 4; i++) begin
                d  = (int'(l[1:0]) + i) % 4;
                nx = cx + dx[d];
                ny = cy + dy[d];
                if (!fnd && nx >= 1 && nx <= w - 2 && ny >= 1 && ny <= h - 2
                    && m_img[nx + MW * ny]) begin
                    fnd = 1;
                    tx = nx;
                    ty = ny;
                end
            end
            t++;
            l = lstep(l);
            if (fnd) begin
                sx.push_back(cx);
                sy.push_back(cy);
                m_img[(cx + tx) / 2 + MW * ((cy + ty) / 2)] = 1'b0;
                m_img[tx + MW * ty] = 1'b0;
                cx = tx;
                cy = ty;
                t++;
                l = lstep(l);
            end else if (sx.size() == 0) begin
                m_img[MW] = 1'b0;
                m_img[(w - 1) + MW * (h - 2)] = 1'b0;
                t_done = t + 2;
                return;
            end else begin
                t += 2;
                l = lstep(lstep(l));
                cx = sx.pop_back();
                cy = sy.pop_back();
            end
        end
    endtask

    task automatic check_maze(input string tag, input int w, input int h);
        bit seen [NB];
        int q [$];
        int zeros, outside, open_cells, edges, reached, cells, p, x, y;
        zeros = 0;
        outside = 0;
        open_cells = 0;
        edges = 0;
        reached = 0;
        for (int yy = 0; yy < MH; yy++) begin
            for (int xx = 0; xx < MW; xx++) begin
                if (!path_data[xx + MW * yy]) begin
                    zeros++;
                    if (xx >= w || yy >= h) outside++;
                    if (xx + 1 < MW && !path_data[xx + 1 + MW * yy]) edges++;
                    if (yy + 1 < MH && !path_data[xx + MW * (yy + 1)]) edges++;
                end
            end
        end
        for (int yy = 1; yy < h; yy += 2) begin
            for (int xx = 1; xx < w; xx += 2) begin
                if (!path_data[xx + MW * yy]) open_cells++;
            end
        end
        if (!path_data[MW]) begin
            seen[MW] = 1'b1;
            q.push_back(MW);
        end
        while (q.size() > 0) begin
            p = q.pop_front();
            reached++;
            x = p % MW;
            y = p / MW;
            if (x > 0 && !path_data[p - 1] && !seen[p - 1]) begin
                seen[p - 1] = 1'b1; q.push_back(p - 1);
            end
            if (x < MW - 1 && !path_data[p + 1] && !seen[p + 1]) begin
                seen[p + 1] = 1'b1; q.push_back(p + 1);
            end
            if (y > 0 && !path_data[p - MW] && !seen[p - MW]) begin
                seen[p - MW] = 1'b1; q.push_back(p - MW);
            end
            if (y < MH - 1 && !path_data[p + MW] && !seen[p + MW]) begin
                seen[p + MW] = 1'b1; q.push_back(p + MW);
            end
        end
        cells = ((w - 1) / 2) * ((h - 1) / 2);
        check_eq({tag, "_zeros"}, zeros, 2 * cells + 1);
        check_eq({tag, "_outside"}, outside, 0);
        check_eq({tag, "_cells_open"}, open_cells, cells);
        check_eq({tag, "_edges"}, edges, 2 * cells);
        check_eq({tag, "_reached"}, reached, 2 * cells + 1);
        check_eq({tag, "_exit"}, seen[(w - 1) + MW * (h - 2)], 1);
    endtask

    task automatic run_case(input string tag, input int w, input int h,
                            input logic [15:0] sd, input int poke);
        int t_exp, cyc, lim, bound;
        bit e_exp;
        model_run(w, h, sd, t_exp, e_exp);
        bound = 5 * ((w - 1) / 2) * ((h - 1) / 2) + 6;
        lim = bound + 10;
        maze_width = 7'(w);
        maze_height = 7'(h);
        seed = sd;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        check_eq({tag, "_busy_run"}, busy, 1);
        cyc = 0;
        while (!done && cyc < lim) begin
            if (cyc == poke) begin
                seed = ~sd;
                start = 1'b1;
            end
            @(posedge clk);
            #1;
            start = 1'b0;
            cyc++;
        end
        check_eq({tag, "_cycles"}, cyc, t_exp);
        check_eq({tag, "_done"}, done, 1);
        check_eq({tag, "_busy_end"}, busy, 0);
        check_eq({tag, "_err"}, err, e_exp);
        check_eq({tag, "_img_diff"}, $countones(path_data ^ m_img), 0);
        if (e_exp) begin
            check_eq({tag, "_zeros"}, $countones(~path_data), 0);
        end else begin
            check_eq({tag, "_in_bound"}, cyc <= bound, 1);
            check_maze(tag, w, h);
        end
    endtask

    initial begin
        int cyc;
        int rw, rh;
        reset = 1'b1;
        start = 1'b0;
        maze_width = 7'd3;
        maze_height = 7'd3;
        seed = 16'h0;
        repeat (3) @(posedge clk);
        #1;
        check_eq("rst_busy", busy, 0);
        check_eq("rst_done", done, 0);
        check_eq("rst_err", err, 0);
        check_eq("rst_zeros", $countones(~path_data), 0);
        reset = 1'b0;
        @(posedge clk);
        #1;

        run_case("t1", 3, 3, 16'h0001, -1);
        check_eq("t1_cells", {path_data[MW], path_data[MW + 1], path_data[MW + 2]}, 0);
        run_case("t2", 5, 5, 16'h1234, -1);
        run_case("t3a", 21, 15, 16'hBEEF, -1);
        img1 = path_data;
        run_case("t3b", 21, 15, 16'hBEEF, -1);
        check_eq("t3_repeat", $countones(path_data ^ img1), 0);
        run_case("t3z", 11, 9, 16'h0000, -1);
        img1 = path_data;
        run_case("t3s", 11, 9, 16'hACE1, -1);
        check_eq("t3_zero_seed", $countones(path_data ^ img1), 0);

        run_case("t4_even_w", 4, 5, 16'h0042, -1);
        run_case("t4_wide", 101, 5, 16'h0042, -1);
        run_case("t4_short", 5, 1, 16'h0042, -1);
        run_case("t4_tall", 3, 103, 16'h0042, -1);
        run_case("t4_even_h", 7, 8, 16'h0042, -1);

        run_case("ignore", 21, 15, 16'h0F0F, 40);

        // Abort a large run with reset partway through.
        maze_width = 7'd99;
        maze_height = 7'd99;
        seed = 16'h7777;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        cyc = 0;
        while (cyc < 500) begin
            start = (cyc == 100 || cyc == 300);
            @(posedge clk);
            #1;
            start = 1'b0;
            cyc++;
        end
        check_eq("t5_busy_mid", busy, 1);
        check_eq("t5_done_mid", done, 0);
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        check_eq("t5_busy_rst", busy, 0);
        check_eq("t5_done_rst", done, 0);
        check_eq("t5_err_rst", err, 0);
        check_eq("t5_zeros_rst", $countones(~path_data), 0);

        run_case("t5_rerun", 9, 7, 16'h3C3C, -1);
        start = 1'b1;
        reset = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        reset = 1'b0;
        check_eq("rst_wins_busy", busy, 0);
        check_eq("rst_wins_done", done, 0);
        check_eq("rst_wins_zeros", $countones(~path_data), 0);

        run_case("t6", MW - 1, MH - 1, 16'h5A5A, -1);

        for (int k = 0; k < 6; k++) begin
            rw = 2 * $urandom_range(1, 15) + 1;
            rh = 2 * $urandom_range(1, 15) + 1;
            run_case($sformatf("rnd%0d", k), rw, rh, 16'($urandom), -1);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
